// File: rtl/booth_multiplier_seq_if.sv
// Start/busy/done handshake and operand/product bus for the sequential Booth multiplier.
// The datapath control is the master; the multiplier is the slave.
interface booth_multiplier_seq_if #(
    parameter int WIDTH = 32
);
    logic                   start;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     z;

    modport master (
        output start,
        output multiplicand,
        output multiplier,
        input  busy,
        input  done,
        input  z
    );

    modport slave (
        input  start,
        input  multiplicand,
        input  multiplier,
        output busy,
        output done,
        output z
    );
endinterface

// File: rtl/booth_multiplier_seq.sv
// Sequential signed WIDTHxWIDTH multiplier, radix-4 Booth recoding, one digit per clock.
// Product is packed {HI, LO} like the divider's {remainder, quotient}.
module booth_multiplier_seq #(
    parameter int WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   clear,
    booth_multiplier_seq_if.slave  bus
);
    localparam int DIGITS = WIDTH / 2;
    localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     count;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   m_sh;     // multiplicand, sign-extended, pre-shifted by 2i
    logic [WIDTH-1:0]     q_reg;    // multiplier, consumed two bits per digit
    logic                 q_prev;   // Q[2i-1] for the current triplet
    logic [2*WIDTH-1:0]   pp;

    logic                 busy_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   z_q;

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.z    = z_q;

    // Full 2*WIDTH-bit partial products keep +-2M exact even for M = -2^(WIDTH-1).
    always_comb begin
        // NOTE: default first so no path through the case leaves pp unassigned (no latch).
        pp = '0;
        case ({q_reg[1], q_reg[0], q_prev})
            3'b001, 3'b010: pp = m_sh;
            3'b011:         pp = m_sh << 1;
            3'b100:         pp = -(m_sh << 1);
            3'b101, 3'b110: pp = -m_sh;
            default:        pp = '0;
        endcase
    end

    // NOTE: datapath registers (acc, m_sh, q_reg, q_prev) are loaded on every accepted
    // start, so only control and visible outputs need the clear.
    always_ff @(posedge clock) begin
        if (clear) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            z_q    <= '0;
            count  <= '0;
        end else begin
            // NOTE: non-blocking throughout so every register sees pre-edge values.
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        m_sh   <= {{WIDTH{bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
                        q_reg  <= bus.multiplier;
                        q_prev <= 1'b0;
                        acc    <= '0;
                        count  <= '0;
                        busy_q <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    acc    <= acc + pp;
                    m_sh   <= m_sh << 2;
                    q_reg  <= q_reg >> 2;
                    q_prev <= q_reg[1];
                    if (count == LAST_DIGIT) begin
                        busy_q <= 1'b0;
                        state  <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    // busy is already low here, but start is still not accepted.
                    z_q    <= acc;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Scoreboard bench for booth_multiplier_seq: expected products queued at issue,
// compared on each done pulse against a 64-bit signed reference.
module tb_booth_multiplier_seq;
    localparam int WIDTH = 32;

    logic clock = 1'b0;
    logic clear;
    always #5 clock = ~clock;

    booth_multiplier_seq_if #(.WIDTH(WIDTH)) bus ();

    booth_multiplier_seq #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.slave)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] sb[$];
    logic [63:0] last_z   = '0;
    logic        prev_done = 1'b0;
    bit          mon_en   = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb_;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        return 64'(sa * sb_);
    endfunction

    // Output monitor: products on done, single-cycle done, z held between dones.
    always @(posedge clock) begin
        #1;
        if (mon_en) begin
            if (bus.done) begin
                check("done_pulse", {63'b0, prev_done}, 64'd0);
                if (sb.size() == 0) check("spurious_done", {63'b0, bus.done}, 64'd0);
                else check("product", bus.z, sb.pop_front());
                last_z = bus.z;
            end else begin
                check("z_stable", bus.z, last_z);
            end
            prev_done = bus.done;
        end
    end

    // Issue one operation and wait for its done; reports latency and busy cycles.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_cyc);
        int k;
        k = 0;
        busy_cyc = 0;
        @(negedge clock);
        bus.start = 1'b1;
        bus.multiplicand = a;
        bus.multiplier = b;
        sb.push_back(ref_mul(a, b));
        do begin
            @(posedge clock);
            #1;
            k++;
            if (bus.busy) busy_cyc++;
            if (k == 1) begin
                bus.start = 1'b0;
                bus.multiplicand = $urandom;
                bus.multiplier = $urandom;
            end
        end while (!bus.done && k < 40);
        if (!bus.done) check("timeout", {63'b0, bus.done}, 64'd1);
        lat = k - 1;
    endtask

    task automatic wait_done(input int max_cyc, output int waited);
        waited = 0;
        do begin
            @(posedge clock);
            #1;
            waited++;
        end while (!bus.done && waited < max_cyc);
        if (!bus.done) check("timeout", {63'b0, bus.done}, 64'd1);
    endtask

    initial begin
        int lat, bcyc, k;
        logic [31:0] a, b;

        bus.start = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier = '0;
        clear = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("reset_z", bus.z, 64'd0);
        check("reset_busy", {63'b0, bus.busy}, 64'd0);
        check("reset_done", {63'b0, bus.done}, 64'd0);
        @(negedge clock);
        clear = 1'b0;
        mon_en = 1'b1;

        // Clear mid-CALC discards the in-flight operation.
        @(negedge clock);
        bus.start = 1'b1;
        bus.multiplicand = 32'd123;
        bus.multiplier = 32'd456;
        sb.push_back(ref_mul(32'd123, 32'd456));
        @(negedge clock);
        bus.start = 1'b0;
        repeat (8) @(negedge clock);
        clear = 1'b1;
        sb.delete();
        @(posedge clock);
        #1;
        check("clear_busy", {63'b0, bus.busy}, 64'd0);
        check("clear_done", {63'b0, bus.done}, 64'd0);
        check("clear_z", bus.z, 64'd0);
        @(negedge clock);
        clear = 1'b0;
        repeat (25) @(negedge clock);

        // Latency and busy width.
        do_op(32'd7, 32'hFFFF_FFFD, lat, bcyc);
        check("latency", 64'(lat), 64'd17);
        check("busy_cycles", 64'(bcyc), 64'd16);
        check("z_7x-3", bus.z, 64'hFFFF_FFFF_FFFF_FFEB);

        // Boundary operands.
        do_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, lat, bcyc);
        check("z_maxpos_sq", bus.z, 64'h3FFF_FFFF_0000_0001);
        do_op(32'h8000_0000, 32'h8000_0000, lat, bcyc);
        check("z_minneg_sq", bus.z, 64'h4000_0000_0000_0000);
        do_op(32'h8000_0000, 32'd1, lat, bcyc);
        check("z_minneg_x1", bus.z, 64'hFFFF_FFFF_8000_0000);
        do_op(32'd0, 32'hDEAD_BEEF, lat, bcyc);
        check("z_zero", bus.z, 64'd0);

        // Start during CALC is ignored.
        @(negedge clock);
        bus.start = 1'b1;
        bus.multiplicand = 32'h1234_5678;
        bus.multiplier = 32'hFEDC_BA98;
        sb.push_back(ref_mul(32'h1234_5678, 32'hFEDC_BA98));
        k = 0;
        do begin
            @(posedge clock);
            #1;
            k++;
            if (k == 1) bus.start = 1'b0;
            if (k == 6) begin
                bus.start = 1'b1;
                bus.multiplicand = 32'd3;
                bus.multiplier = 32'd5;
            end
            if (k == 7) bus.start = 1'b0;
        end while (!bus.done && k < 40);
        check("ignored_start_latency", 64'(k - 1), 64'd17);

        // Start held high: one result every 18 cycles.
        @(negedge clock);
        a = $urandom;
        b = $urandom;
        bus.start = 1'b1;
        bus.multiplicand = a;
        bus.multiplier = b;
        sb.push_back(ref_mul(a, b));
        wait_done(40, k);
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom;
            bus.multiplicand = a;
            bus.multiplier = b;
            sb.push_back(ref_mul(a, b));
            wait_done(40, k);
            check("b2b_period", 64'(k), 64'd18);
        end
        bus.start = 1'b0;
        repeat (3) @(negedge clock);

        // Random signed operands.
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 50 == 0) a = 32'h8000_0000;
            if (i % 70 == 0) b = 32'hFFFF_FFFF;
            do_op(a, b, lat, bcyc);
        end

        repeat (4) @(negedge clock);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
